// File: rtl/axi_line_writer_if.sv
// AXI4 write-address, write-data and write-response channels between the line
// writer (master) and the interconnect write port (slave).
interface axi_line_writer_if #(
    parameter int unsigned ID_W = 4
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_line_writer.sv
// Drains one 128-bit write-buffer line as a single 4-beat AXI4 INCR burst and
// pulses done_o (with err_o on a non-OKAY response) once the B response lands.
module axi_line_writer #(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic [31:0]   addr_i,
    input  logic [127:0]  data_i,
    output logic          done_o,
    output logic          err_o,
    output logic          busy_o,
    axi_line_writer_if.master axi
);
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [BEATS-1:0][BEAT_W-1:0]  line;
    logic [31:0]                   awaddr_q;
    logic [BEAT_W-1:0]             wdata_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic                          wlast_q;
    logic                          bready_q;

    // Fixed burst shape: 4 beats of full 32-bit words, incrementing.
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 8'(BEATS - 1);
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.wstrb   = 4'hF;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Line offset bits and the response ID carry no information for this engine.
    logic unused_bits;
    assign unused_bits = ^{addr_i[3:0], axi.bid};

    // Burst sequencer; every output is registered so it is stable for a whole cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        line      <= data_i;
                        awaddr_q  <= {addr_i[31:4], 4'b0000};
                        awvalid_q <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= line[0];
                        wlast_q   <= 1'b0;
                        cnt       <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (axi.wready) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BEATS - 1)) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            wdata_q  <= '0;
                            bready_q <= 1'b1;
                            state    <= RESP;
                        end else begin
                            wdata_q <= line[cnt + CNT_W'(1)];
                            wlast_q <= (cnt == CNT_W'(BEATS - 2));
                        end
                    end
                end
                RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        done_o   <= 1'b1;
                        err_o    <= (axi.bresp != 2'b00);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // One dead cycle so the buffer's retired head is visible before re-sampling req_i.
                    busy_o   <= 1'b0;
                    awaddr_q <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_line_writer.sv
// Randomised bench for axi_line_writer: a write-buffer queue drives requests,
// a scripted AXI slave applies per-line stalls, and a transaction model checks the bus.
module tb_axi_line_writer;
    localparam int unsigned ID_W    = 4;
    localparam int          MAX_CYC = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic [31:0]   addr_i;
    logic [127:0]  data_i;
    logic          done_o;
    logic          err_o;
    logic          busy_o;

    axi_line_writer_if #(.ID_W(ID_W)) axi ();

    axi_line_writer #(.ID_W(ID_W), .AXI_ID(4'h1)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .done_o (done_o),
        .err_o  (err_o),
        .busy_o (busy_o),
        .axi    (axi)
    );

    always #5 clk = ~clk;

    // One buffered line plus the slave's behaviour while it is being written.
    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [1:0]   bresp;
        int           aw_stall;
        int           w_beat;
        int           w_n;
        int           b_stall;
        int           gap;
        bit           rst_mid;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bit   busy_m, aw_done, b_done, done_now, exp_av, exp_wv, exp_br, exp_dn, drive_rst;
    int   exp_done, beats, aw_wait, w_wait, b_wait, aw_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] a, input logic [127:0] d, input logic [1:0] br,
                                input int aws, input int wb, input int wn, input int bs,
                                input int gap, input bit rm);
        ent_t r;
        r.addr = a;   r.data = d;   r.bresp = br;
        r.aw_stall = aws; r.w_beat = wb; r.w_n = wn; r.b_stall = bs;
        r.gap = gap;  r.rst_mid = rm;
        return r;
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d0;
        d0 = 128'h44444444_33333333_22222222_11111111;
        rst = 1'b0; req_i = 1'b0; addr_i = '0; data_i = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bresp = 2'b00; axi.bid = '0;
        busy_m = 1'b0; aw_done = 1'b0; b_done = 1'b0;
        exp_done = 0; beats = 0; aw_wait = 0; w_wait = 0; b_wait = 0; aw_cnt = 0;

        // Directed lines: zero-wait, AW stall, W stall, SLVERR then OKAY, back-to-back pair, reset mid-burst.
        q.push_back(mk(32'h1000_0ABC, d0, 2'b00, 0, 0, 0, 0, 0, 1'b0));
        q.push_back(mk($urandom, rnd_line(), 2'b00, 3, 0, 0, 0, 0, 1'b0));
        q.push_back(mk($urandom, d0, 2'b00, 0, 2, 2, 0, 0, 1'b0));
        q.push_back(mk($urandom, rnd_line(), 2'b10, 0, 0, 0, 0, 0, 1'b0));
        q.push_back(mk($urandom, rnd_line(), 2'b00, 0, 0, 0, 0, 0, 1'b0));
        q.push_back(mk(32'hA000_0010, rnd_line(), 2'b00, 0, 0, 0, 0, 0, 1'b0));
        q.push_back(mk(32'hB000_0020, rnd_line(), 2'b00, 0, 0, 0, 0, 0, 1'b0));
        q.push_back(mk($urandom, rnd_line(), 2'b00, 0, 0, 0, 0, 0, 1'b1));
        for (int i = 0; i < 40; i++)
            q.push_back(mk($urandom, rnd_line(), 2'($urandom_range(0, 3)),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), (i == 20)));

        repeat (3) @(negedge clk);

        while ((q.size() != 0 || busy_m) && cyc < MAX_CYC) begin
            e = (q.size() != 0) ? q[0] : mk('0, '0, 2'b00, 0, 0, 0, 0, 0, 1'b0);

            // Expected bus state for this cycle from the transaction's progress.
            exp_av = busy_m && !aw_done;
            exp_wv = busy_m && aw_done && beats < 4;
            exp_br = busy_m && beats == 4 && !b_done;
            exp_dn = busy_m && cyc == exp_done;
            chk("busy",    128'(busy_o),      128'(busy_m));
            chk("awvalid", 128'(axi.awvalid), 128'(exp_av));
            chk("wvalid",  128'(axi.wvalid),  128'(exp_wv));
            chk("bready",  128'(axi.bready),  128'(exp_br));
            chk("done",    128'(done_o),      128'(exp_dn));
            chk("err",     128'(err_o),       128'(exp_dn && e.bresp != 2'b00));
            if (exp_av) begin
                chk("awaddr",  128'(axi.awaddr),  128'({e.addr[31:4], 4'b0000}));
                chk("awlen",   128'(axi.awlen),   128'(3));
                chk("awsize",  128'(axi.awsize),  128'(2));
                chk("awburst", 128'(axi.awburst), 128'(1));
                chk("awid",    128'(axi.awid),    128'(1));
            end
            if (exp_wv) begin
                chk("wdata", 128'(axi.wdata), 128'(e.data[32*beats +: 32]));
                chk("wlast", 128'(axi.wlast), 128'(beats == 3));
                chk("wstrb", 128'(axi.wstrb), 128'(15));
            end
            if (!busy_m) begin
                chk("idle_awaddr", 128'(axi.awaddr), 128'(0));
                chk("idle_wdata",  128'(axi.wdata),  128'(0));
            end

            done_now = done_o && busy_m;
            if (done_now) begin
                chk("aw_hs", 128'(aw_cnt), 128'(1));
                chk("w_hs",  128'(beats),  128'(4));
                chk("b_hs",  128'(b_done), 128'(1));
                busy_m = 1'b0;
            end

            // Write-buffer side: head stays presented through the done edge, then retires.
            drive_rst = !(busy_m && e.rst_mid && beats == 2);
            rst = drive_rst;
            if (done_now) begin
                req_i = 1'b1; addr_i = e.addr; data_i = e.data;
            end else if (busy_m) begin
                req_i = 1'($urandom_range(0, 1)); addr_i = $urandom; data_i = rnd_line();
            end else if (q.size() != 0 && q[0].gap > 0) begin
                q[0].gap = q[0].gap - 1;
                req_i = 1'b0; addr_i = $urandom; data_i = rnd_line();
            end else if (q.size() != 0) begin
                req_i = 1'b1; addr_i = e.addr; data_i = e.data;
                busy_m = 1'b1;
                exp_done = cyc + 7 + e.aw_stall + e.w_n + e.b_stall;
                aw_done = 1'b0; b_done = 1'b0; beats = 0; aw_cnt = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                req_i = 1'b0;
            end

            // Scripted slave.
            if (axi.awvalid) begin
                axi.awready = (aw_wait >= e.aw_stall);
                if (!axi.awready) aw_wait++;
            end else axi.awready = 1'($urandom_range(0, 1));
            if (axi.wvalid) begin
                axi.wready = !(beats == e.w_beat && w_wait < e.w_n);
                if (!axi.wready) w_wait++;
            end else axi.wready = 1'($urandom_range(0, 1));
            if (busy_m && beats == 4 && !b_done) begin
                axi.bvalid = (b_wait >= e.b_stall);
                if (!axi.bvalid) b_wait++;
            end else axi.bvalid = 1'b0;
            axi.bresp = axi.bvalid ? e.bresp : 2'($urandom);
            axi.bid   = ID_W'($urandom);

            if (drive_rst) begin
                if (busy_m && axi.wvalid && axi.wready) beats++;
                if (busy_m && axi.awvalid && axi.awready) begin aw_done = 1'b1; aw_cnt++; end
                if (busy_m && axi.bready && axi.bvalid) b_done = 1'b1;
            end else begin
                busy_m = 1'b0;
                q[0].rst_mid = 1'b0;
            end
            if (done_now) void'(q.pop_front());

            @(negedge clk);
            cyc++;
        end

        chk("timeout", 128'(cyc < MAX_CYC), 128'(1));
        chk("drain",   128'(q.size()),      128'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
